// File: rtl/tlb_lookup.sv
// Set-associative TLB: hit response in the cycle after accept; on a miss the page walk result is registered and returned the cycle after it arrives.
// One request at a time; req_ready is high only in IDLE, and walk_req_valid holds with a stable address until walk_req_ready.
module tlb_lookup #(
    parameter int SADDR = 64,
    parameter int SPAGE = 12,
    parameter int NSET  = 8,
    parameter int SPCID = 12,
    parameter int NWAY  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [SADDR-1:0]       req_va,
    input  logic [SPCID-1:0]       req_pcid,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic                   resp_fault,
    output logic [SADDR-1:0]       resp_pa,
    output logic                   walk_req_valid,
    input  logic                   walk_req_ready,
    output logic [SADDR-1:0]       walk_va,
    output logic [SPCID-1:0]       walk_pcid,
    input  logic                   walk_resp_valid,
    input  logic [SADDR-SPAGE-1:0] walk_resp_ppn,
    input  logic                   walk_resp_fault,
    input  logic                   flush
);
    localparam int IDXW = $clog2(NSET);
    localparam int WAYW = $clog2(NWAY);
    localparam int TAGW = SADDR - SPAGE - IDXW;
    localparam int PPNW = SADDR - SPAGE;

    typedef enum logic [1:0] {IDLE, LOOKUP, WALK_REQ, WALK_WAIT} state_t;

    state_t state, state_nx;

    logic [SADDR-1:0] va_q;
    logic [SPCID-1:0] pcid_q;

    logic [NWAY-1:0]  vld      [NSET];
    logic [WAYW-1:0]  rr       [NSET];
    logic [TAGW-1:0]  tag_mem  [NWAY][NSET];
    logic [SPCID-1:0] pcid_mem [NWAY][NSET];
    logic [PPNW-1:0]  ppn_mem  [NWAY][NSET];

    logic [IDXW-1:0] idx;
    logic [TAGW-1:0] tag;
    logic            hit_any;
    logic [WAYW-1:0] hit_way;
    logic [PPNW-1:0] hit_ppn;
    logic            lookup_hit;
    logic            inv_found;
    logic [WAYW-1:0] inv_way;
    logic [WAYW-1:0] victim;
    logic            evict;
    logic            walk_done;
    logic            fill;

    logic             resp_q_vld;
    logic             resp_q_fault;
    logic [SADDR-1:0] resp_q_pa;

    assign idx = va_q[SPAGE +: IDXW];
    assign tag = va_q[SADDR-1 -: TAGW];

    // Descending scan so the lowest matching way is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = NWAY - 1; w >= 0; w--) begin
            if (vld[idx][w] && tag_mem[w][idx] == tag && pcid_mem[w][idx] == pcid_q) begin
                hit_any = 1'b1;
                hit_way = WAYW'(w);
            end
        end
    end

    assign hit_ppn    = ppn_mem[hit_way][idx];
    assign lookup_hit = (state == LOOKUP) && hit_any && !flush;

    // A flush in the fill cycle empties the set first, so way 0 is the free slot.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = NWAY - 1; w >= 0; w--) begin
            if (!vld[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAYW'(w);
            end
        end
        victim = '0;
        evict  = 1'b0;
        if (flush) begin
            victim = '0;
        end else if (inv_found) begin
            victim = inv_way;
        end else begin
            victim = rr[idx];
            evict  = 1'b1;
        end
    end

    assign walk_done = (state == WALK_WAIT) && walk_resp_valid;
    assign fill      = walk_done && !walk_resp_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        req_ready      = 1'b0;
        walk_req_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = LOOKUP;
            end
            LOOKUP: begin
                state_nx = lookup_hit ? IDLE : WALK_REQ;
            end
            WALK_REQ: begin
                walk_req_valid = 1'b1;
                if (walk_req_ready) state_nx = WALK_WAIT;
            end
            WALK_WAIT: begin
                if (walk_resp_valid) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            va_q   <= '0;
            pcid_q <= '0;
        end else if (state == IDLE && req_valid) begin
            va_q   <= req_va;
            pcid_q <= req_pcid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSET; s++) begin
                vld[s] <= '0;
                rr[s]  <= '0;
            end
        end else begin
            if (flush) begin
                for (int s = 0; s < NSET; s++) begin
                    vld[s] <= '0;
                    rr[s]  <= '0;
                end
            end
            if (fill) begin
                vld[idx][victim] <= 1'b1;
                if (evict) rr[idx] <= rr[idx] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[victim][idx]  <= tag;
            pcid_mem[victim][idx] <= pcid_q;
            ppn_mem[victim][idx]  <= walk_resp_ppn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_q_vld   <= 1'b0;
            resp_q_fault <= 1'b0;
            resp_q_pa    <= '0;
        end else begin
            resp_q_vld   <= walk_done;
            resp_q_fault <= walk_done && walk_resp_fault;
            resp_q_pa    <= fill ? {walk_resp_ppn, va_q[SPAGE-1:0]} : '0;
        end
    end

    assign resp_valid = lookup_hit | resp_q_vld;
    assign resp_hit   = lookup_hit;
    assign resp_fault = resp_q_fault;
    assign resp_pa    = lookup_hit ? {hit_ppn, va_q[SPAGE-1:0]} : resp_q_pa;
    assign walk_va    = walk_req_valid ? va_q : '0;
    assign walk_pcid  = walk_req_valid ? pcid_q : '0;

endmodule

// File: tb/tb_tlb_lookup.sv
// Bench for tlb_lookup: directed vector table, hand-written flush/reset sequences, then random traffic against an array model.
module tb_tlb_lookup;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_va;
    logic [11:0] req_pcid;
    logic        resp_valid;
    logic        resp_hit;
    logic        resp_fault;
    logic [63:0] resp_pa;
    logic        walk_req_valid;
    logic        walk_req_ready;
    logic [63:0] walk_va;
    logic [11:0] walk_pcid;
    logic        walk_resp_valid;
    logic [51:0] walk_resp_ppn;
    logic        walk_resp_fault;
    logic        flush;

    tlb_lookup dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_pcid(req_pcid),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_fault(resp_fault), .resp_pa(resp_pa),
        .walk_req_valid(walk_req_valid), .walk_req_ready(walk_req_ready),
        .walk_va(walk_va), .walk_pcid(walk_pcid),
        .walk_resp_valid(walk_resp_valid), .walk_resp_ppn(walk_resp_ppn),
        .walk_resp_fault(walk_resp_fault), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference TLB: 8 ways x 8 sets, full VPN stored, per-set replacement pointer.
    logic        m_vld  [8][8];
    logic [51:0] m_vpn  [8][8];
    logic [11:0] m_pcid [8][8];
    logic [51:0] m_ppn  [8][8];
    int          m_rr   [8];

    typedef struct {
        logic [63:0] va;
        logic [11:0] pcid;
        logic [51:0] ppn;
        logic        fault;
        int          dly;
        logic        ehit;
        logic        efault;
        logic [63:0] epa;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic m_clear();
        for (int s = 0; s < 8; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < 8; w++) m_vld[w][s] = 1'b0;
        end
    endtask

    task automatic m_lookup(input logic [63:0] va, input logic [11:0] pcid,
                            output logic hit, output logic [51:0] ppn);
        int s;
        s   = int'(va[14:12]);
        hit = 1'b0;
        ppn = '0;
        for (int w = 0; w < 8; w++) begin
            if (!hit && m_vld[w][s] && m_vpn[w][s] == va[63:12] && m_pcid[w][s] == pcid) begin
                hit = 1'b1;
                ppn = m_ppn[w][s];
            end
        end
    endtask

    task automatic m_fill(input logic [63:0] va, input logic [11:0] pcid,
                          input logic [51:0] ppn, input logic ff);
        int s;
        int v;
        if (ff) m_clear();
        s = int'(va[14:12]);
        v = -1;
        for (int w = 0; w < 8; w++) if (v < 0 && !m_vld[w][s]) v = w;
        if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % 8;
        end
        m_vld[v][s]  = 1'b1;
        m_vpn[v][s]  = va[63:12];
        m_pcid[v][s] = pcid;
        m_ppn[v][s]  = ppn;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        step();
        flush = 1'b0;
        m_clear();
    endtask

    // Starts and ends at a falling edge with the DUT idle.
    task automatic xact(input logic [63:0] va, input logic [11:0] pcid, input logic [51:0] ppn,
                        input logic fault, input int dly, input logic ff,
                        input logic ehit, input logic efault, input logic [63:0] epa);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_va    = va;
        req_pcid  = pcid;
        step();
        req_valid = 1'b0;
        check("resp_valid_lookup", 64'(resp_valid), 64'(ehit));
        if (ehit) begin
            check("resp_hit", 64'(resp_hit), 64'd1);
            check("resp_fault_hit", 64'(resp_fault), 64'd0);
            check("resp_pa_hit", resp_pa, epa);
            step();
            check("resp_valid_after_hit", 64'(resp_valid), 64'd0);
        end else begin
            step();
            check("walk_req_valid", 64'(walk_req_valid), 64'd1);
            check("walk_va", walk_va, va);
            check("walk_pcid", 64'(walk_pcid), 64'(pcid));
            for (int i = 0; i < dly; i++) begin
                step();
                check("walk_req_valid_hold", 64'(walk_req_valid), 64'd1);
                check("walk_va_hold", walk_va, va);
            end
            walk_req_ready = 1'b1;
            step();
            walk_req_ready = 1'b0;
            check("walk_req_valid_drop", 64'(walk_req_valid), 64'd0);
            check("resp_valid_wait", 64'(resp_valid), 64'd0);
            walk_resp_valid = 1'b1;
            walk_resp_ppn   = ppn;
            walk_resp_fault = fault;
            flush           = ff;
            step();
            walk_resp_valid = 1'b0;
            walk_resp_fault = 1'b0;
            flush           = 1'b0;
            check("resp_valid_walk", 64'(resp_valid), 64'd1);
            check("resp_hit_walk", 64'(resp_hit), 64'd0);
            check("resp_fault_walk", 64'(resp_fault), 64'(efault));
            check("resp_pa_walk", resp_pa, epa);
            if (!fault) m_fill(va, pcid, ppn, ff);
            step();
            check("resp_valid_after_walk", 64'(resp_valid), 64'd0);
            check("resp_pa_idle", resp_pa, 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        h;
        logic [51:0] hp;
        logic [63:0] va;
        logic [11:0] pcid;
        logic [51:0] ppn;
        logic        fault;

        rst_n = 1'b0; req_valid = 1'b0; req_va = '0; req_pcid = '0;
        walk_req_ready = 1'b0; walk_resp_valid = 1'b0; walk_resp_ppn = '0;
        walk_resp_fault = 1'b0; flush = 1'b0;
        m_clear();

        tbl[0] = '{64'h1234, 12'd5, 52'hABCDE, 1'b0, 0, 1'b0, 1'b0, 64'hABCDE234};
        tbl[1] = '{64'h1234, 12'd5, 52'h0,     1'b0, 0, 1'b1, 1'b0, 64'hABCDE234};
        tbl[2] = '{64'h1234, 12'd6, 52'h11111, 1'b0, 0, 1'b0, 1'b0, 64'h11111234};
        tbl[3] = '{64'h5678, 12'd1, 52'h333,   1'b1, 5, 1'b0, 1'b1, 64'h0};
        tbl[4] = '{64'h5678, 12'd1, 52'h333,   1'b0, 0, 1'b0, 1'b0, 64'h333678};

        step(); step();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_walk_req_valid", 64'(walk_req_valid), 64'd0);
        check("rst_resp_pa", resp_pa, 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++)
            xact(tbl[i].va, tbl[i].pcid, tbl[i].ppn, tbl[i].fault, tbl[i].dly, 1'b0,
                 tbl[i].ehit, tbl[i].efault, tbl[i].epa);

        walk_resp_valid = 1'b1;
        walk_resp_ppn   = 52'h77;
        step();
        walk_resp_valid = 1'b0;
        check("stray_walk_resp", 64'(resp_valid), 64'd0);
        step();
        check("stray_walk_resp_next", 64'(resp_valid), 64'd0);

        flush_pulse();
        xact(64'h1234, 12'd5, 52'hABCDE, 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'hABCDE234);
        xact(64'h9ABC, 12'd2, 52'h44, 1'b0, 0, 1'b1, 1'b0, 1'b0, 64'h44ABC);
        xact(64'h9ABC, 12'd2, 52'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 64'h44ABC);
        xact(64'h1234, 12'd5, 52'hABCDE, 1'b0, 1, 1'b0, 1'b0, 1'b0, 64'hABCDE234);

        flush_pulse();
        for (int k = 0; k < 9; k++)
            xact(64'h1000 + 64'(k) * 64'h8000, 12'd3, 52'h100 + 52'(k), 1'b0, 0, 1'b0,
                 1'b0, 1'b0, {52'h100 + 52'(k), 12'h000});
        xact(64'h9000, 12'd3, 52'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 64'h101000);
        xact(64'h1000, 12'd3, 52'h200, 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'h200000);

        xact(64'h7000, 12'd9, 52'h55, 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'h55000);
        xact(64'h7000, 12'd9, 52'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 64'h55000);
        req_valid = 1'b1; req_va = 64'h7000; req_pcid = 12'd7;
        step();
        req_valid = 1'b0;
        step();
        walk_req_ready = 1'b1;
        step();
        walk_req_ready = 1'b0;
        rst_n = 1'b0;
        walk_resp_valid = 1'b1;
        walk_resp_ppn   = 52'h66;
        #1;
        check("rst_mid_walk_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mid_walk_req_ready", 64'(req_ready), 64'd1);
        step();
        walk_resp_valid = 1'b0;
        check("rst_hold_resp_valid", 64'(resp_valid), 64'd0);
        rst_n = 1'b1;
        step();
        check("rst_release_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_release_req_ready", 64'(req_ready), 64'd1);
        m_clear();
        xact(64'h7000, 12'd9, 52'h56, 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'h56000);

        for (int i = 0; i < 80; i++) begin
            va    = (64'($urandom_range(0, 5)) << 15) | (64'($urandom_range(0, 7)) << 12)
                  | 64'($urandom_range(0, 4095));
            pcid  = 12'($urandom_range(1, 2));
            ppn   = 52'($urandom);
            fault = ($urandom_range(0, 7) == 0);
            m_lookup(va, pcid, h, hp);
            if (h)
                xact(va, pcid, ppn, fault, 0, 1'b0, 1'b1, 1'b0, {hp, va[11:0]});
            else
                xact(va, pcid, ppn, fault, int'($urandom_range(0, 2)), 1'b0, 1'b0, fault,
                     fault ? 64'h0 : {ppn, va[11:0]});
            if ($urandom_range(0, 19) == 0) flush_pulse();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tlb_lookup.md
TLB_LOOKUP -- requirements
Module: tlb_lookup

Interface
REQ-001 Parameter SADDR, default 64, virtual/physical address width.
REQ-002 Parameter SPAGE, default 12, page-offset width.
REQ-003 Parameter NSET, default 8, sets per way (power of 2).
REQ-004 Parameter SPCID, default 12, PCID width.
REQ-005 Parameter NWAY, default 8, number of ways (power of 2).
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 req_valid/req_ready  input/output  1/1  lookup request handshake.
REQ-009 req_va  input  SADDR  virtual address; req_pcid  input  SPCID  address-space id.
REQ-010 resp_valid  output  1  one-cycle response pulse; resp_hit  output  1  TLB hit; resp_fault  output  1  walk fault.
REQ-011 resp_pa  output  SADDR  physical address.
REQ-012 walk_req_valid/walk_req_ready  output/input  1/1  page-walk request handshake; walk_va  output  SADDR; walk_pcid  output  SPCID.
REQ-013 walk_resp_valid  input  1; walk_resp_ppn  input  SADDR-SPAGE; walk_resp_fault  input  1.
REQ-014 flush  input  1  invalidate all entries.

Function
REQ-015 Storage: NWAY x NSET entries of {valid, tag, pcid, ppn}. Index = va[SPAGE +: log2(NSET)]; tag = va[SADDR-1 : SPAGE+log2(NSET)]; ppn width SADDR-SPAGE.
REQ-016 Match: valid && tag equal && pcid equal; on multiple matches, lowest way index wins.
REQ-017 FSM states: IDLE, LOOKUP, WALK_REQ, WALK_WAIT.
REQ-018 IDLE: req_ready=1; on req_valid, register va/pcid, go LOOKUP. req_ready=0 in every other state.
REQ-019 LOOKUP (cycle after accept): on hit, resp_valid=1, resp_hit=1, resp_fault=0, resp_pa={ppn, va[SPAGE-1:0]}, go IDLE; on miss, go WALK_REQ.
REQ-020 WALK_REQ: walk_req_valid=1 with walk_va/walk_pcid = registered request; hold stable until walk_req_ready; then go WALK_WAIT.
REQ-021 WALK_WAIT: on walk_resp_valid with fault=0, write entry into the victim way of the indexed set and emit resp_valid=1, resp_hit=0, resp_pa={walk_resp_ppn, offset}; go IDLE.
REQ-022 WALK_WAIT with walk_resp_fault=1: no write; resp_valid=1, resp_fault=1, resp_hit=0, resp_pa=0; go IDLE.
REQ-023 walk_resp_valid outside WALK_WAIT is ignored.
REQ-024 Victim: lowest-index invalid way in the set; if none, per-set round-robin pointer (log2(NWAY) bits), incremented modulo NWAY on each eviction, wrapping NWAY-1 to 0.
REQ-025 Response latency: hit = 1 cycle after accept; miss = same cycle as walk_resp_valid is sampled in WALK_WAIT, registered, output next cycle.
REQ-026 flush: in any cycle, clears all valid bits and round-robin pointers; does not change FSM state. Flush coincident with a fill: flush applies first, the filled entry ends valid.
REQ-027 Flush during LOOKUP: lookup uses post-flush state (miss).
REQ-028 resp_hit/resp_fault/resp_pa are meaningful only when resp_valid=1 and hold 0 otherwise.

Reset
REQ-029 rst_n low: FSM=IDLE, all valid bits 0, round-robin pointers 0, all outputs 0 except req_ready=1 once state is IDLE; applies immediately, mid-walk included; in-flight request dropped with no response.

Verification
REQ-030 Defaults; reset; req va=0x1234, pcid=5 -> walk_req_valid with walk_va=0x1234; walk ppn=0xABCDE -> resp_valid, hit=0, pa=0xABCDE234.
REQ-031 Repeat va=0x1234 pcid=5 -> resp_valid one cycle after accept, hit=1, pa=0xABCDE234; same va with pcid=6 -> walk issued.
REQ-032 Fill 9 distinct tags in set 1 (va=0x1000 + k*0x8000, k=0..8) -> 9th fill evicts way 0; lookup k=0 misses, k=1 hits.
REQ-033 walk_req_ready held low 5 cycles -> walk_req_valid and walk_va stable throughout; walk_resp_fault=1 -> resp_fault=1, pa=0; retry misses.
REQ-034 Flush after REQ-030 -> same va misses; flush in cycle of fill -> entry valid, next lookup hits.
REQ-035 rst_n low during WALK_WAIT -> no resp_valid, req_ready=1 after release, previous hit entry now misses.
